mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 20, meaning the number of valid memory words; addresses >= DEPTH are rejected.
REQ-002 SHALL provide parameter TIMEOUT, default 32, meaning the maximum cycles waited in any MFC-wait state.
REQ-003 SHALL have one clock `clk`; `reset` is synchronous and active-high.
REQ-004 SHALL have ports:
  clk         in   1   system clock
  reset       in   1   synchronous active-high reset
  cpuReq      in   1   access request, level-sampled in IDLE
  cpuR_W      in   1   1=read, 0=write
  cpuAddr     in   16  word address
  cpuDataIn   in   16  write data
  cpuDataOut  out  16  last read data
  cpuDone     out  1   one-cycle completion pulse
  cpuErr      out  1   one-cycle error pulse (range or timeout)
  busy        out  1   1 while an access is in progress
  memAddr     out  16  address to memory
  memDataOut  out  16  write data to memory
  memDataIn   in   16  read data from memory
  R_W         out  1   memory direction, 1=read
  EN          out  1   memory enable; rising edge starts the access
  MFC         in   1   memory-function-complete, asynchronous to clk

Function
REQ-005 SHALL pass MFC through a two-flop synchronizer (mfcS) before any use; raw MFC SHALL NOT drive logic.
REQ-006 SHALL implement the FSM states IDLE, WAIT_MFC and WAIT_REL; all outputs SHALL be registered.
REQ-007 In IDLE with cpuReq=1 and cpuAddr<DEPTH, the block SHALL latch cpuAddr, cpuR_W and cpuDataIn into memAddr, R_W and memDataOut, and enter WAIT_MFC with EN=1 and busy=1 on the next cycle.
REQ-008 In IDLE with cpuReq=1 and cpuAddr>=DEPTH, the block SHALL pulse cpuErr for 1 cycle on the next cycle, keep EN=0, and stay in IDLE.
REQ-009 In WAIT_MFC with mfcS=1, the block SHALL set EN=0 and enter WAIT_REL; if R_W=1 it SHALL capture memDataIn into cpuDataOut on the same edge.
REQ-010 In WAIT_REL with mfcS=0, the block SHALL enter IDLE and assert cpuDone for exactly 1 cycle; busy SHALL be 0 in that cycle.
REQ-011 A timeout counter SHALL clear on entry to WAIT_MFC and to WAIT_REL and increment each cycle in those states.
REQ-012 At count TIMEOUT-1 without the exit condition, the block SHALL set EN=0, enter IDLE and pulse cpuErr for 1 cycle, with no cpuDone.
REQ-013 cpuReq while busy=1 SHALL be ignored; no queueing.
REQ-014 In the cycle cpuDone or cpuErr is asserted, the state is IDLE, so a held cpuReq SHALL be accepted on that edge (back-to-back accesses).
REQ-015 cpuDataOut SHALL change only on a successful read capture (REQ-009); writes, errors and timeouts SHALL leave it unchanged.
REQ-016 memAddr, memDataOut and R_W SHALL hold their latched values until the next accepted request.
REQ-017 cpuDone and cpuErr SHALL never be asserted in the same cycle.
REQ-018 EN SHALL never be high for more than TIMEOUT consecutive cycles, and SHALL be 0 whenever state is not WAIT_MFC.

Reset
REQ-019 On reset=1 at a clk edge: state=IDLE; EN, R_W, busy, cpuDone and cpuErr = 0; memAddr, memDataOut and cpuDataOut = 16'h0000; synchronizer flops and counter = 0.
REQ-020 Reset mid-access SHALL drop EN to 0 on that edge and SHALL produce neither cpuDone nor cpuErr; any later MFC activity SHALL be ignored while in IDLE.

Verification
REQ-021 Read: the memory model holds word 0 = 16'd4 and asserts MFC 2 cycles after EN rises for 4 cycles; cpuReq=1, cpuR_W=1, cpuAddr=0 -> EN high from cycle 1 until mfcS=1, then cpuDataOut=16'd4 and a single cpuDone pulse.
REQ-022 Write then read: write 16'hBEEF to address 7, then read address 7 -> memDataOut=16'hBEEF with R_W=0 during the write; the read returns cpuDataOut=16'hBEEF; two cpuDone pulses.
REQ-023 Range: cpuAddr=20 (DEPTH=20) -> cpuErr pulse the next cycle, EN stays 0, cpuDataOut unchanged.
REQ-024 Timeout: the model never asserts MFC -> EN=0 and a cpuErr pulse exactly TIMEOUT cycles after WAIT_MFC entry (32 with default), no cpuDone.
REQ-025 Back-to-back: cpuReq held high for two reads (addresses 0, 1) -> the second EN rise occurs in the cycle after the first cpuDone, and requests asserted while busy=1 are ignored.
REQ-026 Reset mid-access: reset asserted in WAIT_MFC -> next cycle EN=0, busy=0, all outputs at reset values, and no cpuDone or cpuErr.

Source files
------------

// File: rtl/mem_ctrl.sv
// CPU-to-async-memory handshake controller: latches a request, raises EN, waits on synchronized MFC, then on its release.
// Done/err pulse one cycle after release/fault; requests arriving while busy are dropped (no queueing), a held request is taken back-to-back.
module mem_ctrl #(
  parameter int DEPTH   = 20,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpuReq,
  input  logic        cpuR_W,
  input  logic [15:0] cpuAddr,
  input  logic [15:0] cpuDataIn,
  output logic [15:0] cpuDataOut,
  output logic        cpuDone,
  output logic        cpuErr,
  output logic        busy,
  output logic [15:0] memAddr,
  output logic [15:0] memDataOut,
  input  logic [15:0] memDataIn,
  output logic        R_W,
  output logic        EN,
  input  logic        MFC
);

  typedef enum logic [1:0] {IDLE, WAIT_MFC, WAIT_REL} state_t;

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TLAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic          mfc_meta;
  logic          mfcS;
  logic [CW-1:0] tcnt;
  logic          in_range;
  logic          timed_out;

  assign in_range  = ({16'd0, cpuAddr} < 32'(DEPTH));
  assign timed_out = (tcnt == TLAST);

  // MFC comes from another timing domain; only mfcS may be used past this point.
  always_ff @(posedge clk) begin
    if (reset) begin
      mfc_meta <= 1'b0;
      mfcS     <= 1'b0;
    end else begin
      mfc_meta <= MFC;
      mfcS     <= mfc_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      EN         <= 1'b0;
      R_W        <= 1'b0;
      busy       <= 1'b0;
      cpuDone    <= 1'b0;
      cpuErr     <= 1'b0;
      memAddr    <= 16'h0000;
      memDataOut <= 16'h0000;
      cpuDataOut <= 16'h0000;
    end else begin
      cpuDone <= 1'b0;
      cpuErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuReq) begin
            if (in_range) begin
              memAddr    <= cpuAddr;
              R_W        <= cpuR_W;
              memDataOut <= cpuDataIn;
              EN         <= 1'b1;
              busy       <= 1'b1;
              tcnt       <= '0;
              state      <= WAIT_MFC;
            end else begin
              cpuErr <= 1'b1;
            end
          end
        end
        WAIT_MFC: begin
          if (mfcS) begin
            EN    <= 1'b0;
            tcnt  <= '0;
            state <= WAIT_REL;
            if (R_W) cpuDataOut <= memDataIn;
          end else if (timed_out) begin
            EN     <= 1'b0;
            busy   <= 1'b0;
            cpuErr <= 1'b1;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_REL: begin
          // Completion waits for MFC to drop so the next access sees a clean rising edge.
          if (!mfcS) begin
            busy    <= 1'b0;
            cpuDone <= 1'b1;
            state   <= IDLE;
          end else if (timed_out) begin
            busy   <= 1'b0;
            cpuErr <= 1'b1;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          EN    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural async memory that raises MFC two cycles after EN rises, for four cycles.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        cpuReq;
  logic        cpuR_W;
  logic [15:0] cpuAddr;
  logic [15:0] cpuDataIn;
  logic [15:0] cpuDataOut;
  logic        cpuDone;
  logic        cpuErr;
  logic        busy;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic [15:0] memDataIn;
  logic        R_W;
  logic        EN;
  logic        MFC;

  mem_ctrl #(.DEPTH(20), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .cpuReq(cpuReq), .cpuR_W(cpuR_W), .cpuAddr(cpuAddr),
    .cpuDataIn(cpuDataIn), .cpuDataOut(cpuDataOut), .cpuDone(cpuDone), .cpuErr(cpuErr),
    .busy(busy), .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .R_W(R_W), .EN(EN), .MFC(MFC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word 0 = 4, others 0x1000+index; MFC high while mcnt is 2..5.
  logic [15:0] mem [0:31];
  logic        en_d;
  logic        model_on;
  int          mcnt;

  assign MFC       = (mcnt >= 2);
  assign memDataIn = mem[memAddr[4:0]];

  always @(posedge clk) begin
    en_d <= EN;
    if (reset && !busy && mcnt == 0) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[0] <= 16'd4;
    end
    if (EN && !en_d && model_on) mcnt <= 1;
    else if (mcnt == 5) mcnt <= 0;
    else if (mcnt != 0) mcnt <= mcnt + 1;
    if (mcnt == 2 && !R_W) mem[memAddr[4:0]] <= memDataOut;
  end

  int done_cnt, err_cnt, both_cnt;
  initial begin
    done_cnt = 0; err_cnt = 0; both_cnt = 0; mcnt = 0;
  end
  always @(negedge clk) begin
    if (cpuDone === 1'b1) done_cnt++;
    if (cpuErr === 1'b1) err_cnt++;
    if (cpuDone === 1'b1 && cpuErr === 1'b1) both_cnt++;
  end

  int total, passed, failed;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Issue one request at the current negedge and step until a done/err pulse (bounded).
  task automatic run_access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                            output int cyc, output int en_cyc);
    cpuReq = 1'b1; cpuR_W = rw; cpuAddr = addr; cpuDataIn = wd;
    cyc = 0; en_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      cpuReq = 1'b0;
      if (EN) en_cyc++;
    end while (!cpuDone && !cpuErr && cyc < 100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, en_cyc, snap_done, snap_err, n;
    total = 0; passed = 0; failed = 0;
    reset = 1'b1; cpuReq = 1'b0; cpuR_W = 1'b0; cpuAddr = 16'h0; cpuDataIn = 16'h0; model_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_EN", EN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {cpuDone, cpuErr}, 0);
    chk("rst_memAddr", memAddr, 16'h0000);
    chk("rst_cpuDataOut", cpuDataOut, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Read word 0: accept at +1, MFC seen via sync at +6, release seen at +10.
    run_access(1'b1, 16'd0, 16'h0, cyc, en_cyc);
    chk("rd0_latency", cyc, 10);
    chk("rd0_en_cycles", en_cyc, 5);
    chk("rd0_done", {cpuDone, cpuErr, busy}, 3'b100);
    chk("rd0_data", cpuDataOut, 16'd4);
    @(negedge clk);
    chk("rd0_done_pulse_width", cpuDone, 0);

    run_access(1'b0, 16'd7, 16'hBEEF, cyc, en_cyc);
    chk("wr7_latency", cyc, 10);
    chk("wr7_memDataOut", memDataOut, 16'hBEEF);
    chk("wr7_R_W", R_W, 0);
    chk("wr7_keeps_dataout", cpuDataOut, 16'd4);
    chk("wr7_done", cpuDone, 1);
    @(negedge clk);

    run_access(1'b1, 16'd7, 16'h0, cyc, en_cyc);
    chk("rd7_data", cpuDataOut, 16'hBEEF);
    chk("rd7_done", cpuDone, 1);
    @(negedge clk);

    run_access(1'b1, 16'd19, 16'h0, cyc, en_cyc);
    chk("rd19_edge_accept", {cpuDone, 16'(cyc)}, {1'b1, 16'd10});
    chk("rd19_data", cpuDataOut, 16'h1013);
    @(negedge clk);

    // Address == DEPTH is the first rejected word.
    run_access(1'b1, 16'd20, 16'h0, cyc, en_cyc);
    chk("range_latency", cyc, 1);
    chk("range_err", {cpuErr, cpuDone, EN, busy}, 4'b1000);
    chk("range_en_cycles", en_cyc, 0);
    chk("range_keeps_dataout", cpuDataOut, 16'h1013);
    chk("range_keeps_memAddr", memAddr, 16'd19);
    @(negedge clk);
    chk("range_err_pulse_width", cpuErr, 0);

    model_on = 1'b0;
    run_access(1'b1, 16'd3, 16'h0, cyc, en_cyc);
    chk("tmo_latency", cyc, 33);
    chk("tmo_en_cycles", en_cyc, 32);
    chk("tmo_err", {cpuErr, cpuDone, EN, busy}, 4'b1000);
    chk("tmo_keeps_dataout", cpuDataOut, 16'h1013);
    model_on = 1'b1;
    @(negedge clk);

    // Back-to-back: request held; address changed while busy must be ignored.
    cpuReq = 1'b1; cpuR_W = 1'b1; cpuAddr = 16'd0;
    @(negedge clk);
    chk("b2b_first_EN", {EN, busy}, 2'b11);
    cpuAddr = 16'd1;
    repeat (3) @(negedge clk);
    chk("b2b_busy_ignores_req", memAddr, 16'd0);
    n = 4;
    while (!cpuDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done_cycle", n, 10);
    chk("b2b_first_data", cpuDataOut, 16'd4);
    @(negedge clk);
    chk("b2b_second_EN", {EN, busy, cpuDone}, 3'b110);
    chk("b2b_second_addr", memAddr, 16'd1);
    cpuReq = 1'b0;
    n = 0;
    while (!cpuDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_done_cycle", n, 9);
    chk("b2b_second_data", cpuDataOut, 16'h1001);
    @(negedge clk);

    chk("pulse_done_total", done_cnt, 6);
    chk("pulse_err_total", err_cnt, 2);
    chk("pulse_never_both", both_cnt, 0);

    // Reset while waiting for MFC.
    snap_done = done_cnt; snap_err = err_cnt;
    cpuReq = 1'b1; cpuR_W = 1'b1; cpuAddr = 16'd2;
    @(negedge clk);
    cpuReq = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_in_wait", {EN, busy}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_EN_busy", {EN, busy, R_W}, 3'b000);
    chk("rstmid_addr_data", {memAddr, memDataOut}, 32'h0);
    chk("rstmid_dataout", cpuDataOut, 16'h0000);
    reset = 1'b0;
    en_cyc = 0;
    repeat (20) begin
      @(negedge clk);
      if (EN || busy) en_cyc++;
    end
    chk("rstmid_mfc_ignored", en_cyc, 0);
    chk("rstmid_no_done", done_cnt - snap_done, 0);
    chk("rstmid_no_err", err_cnt - snap_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
